// File: rtl/sound_tone_gen.sv
// Square-wave tone generator: turns rising sound-event classes into fixed-length
// tones whose pitch follows the event class (move / good / bad collision).
module sound_tone_gen #(
    parameter int                PER_W      = 16,
    parameter int                DUR_W      = 24,
    parameter logic [PER_W-1:0]  MOVE_HALF  = 16'd22727,
    parameter logic [PER_W-1:0]  GOOD_HALF  = 16'd9091,
    parameter logic [PER_W-1:0]  BAD_HALF   = 16'd45455,
    parameter logic [DUR_W-1:0]  DUR_CYCLES = 24'd1000000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       playSound,
    input  logic       mode_i,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic [3:0] direction,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] tone_cls
);

    typedef enum logic {
        ST_IDLE,
        ST_PLAY
    } state_t;

    localparam logic [DUR_W-1:0] DUR_LAST = DUR_CYCLES - 1'b1;

    state_t           r_state;
    logic [1:0]       r_cls_q;
    logic [1:0]       r_tone_cls;
    logic [PER_W-1:0] r_half_cnt;
    logic [DUR_W-1:0] r_dur_cnt;
    logic             r_speaker;
    logic             r_busy;

    logic [1:0]       w_cls;
    logic             w_trig;
    logic [PER_W-1:0] w_half;
    logic [PER_W-1:0] w_half_last;

    // Event class with bad > good > move priority; gated by the mode FSM request.
    always_comb begin
        w_cls = 2'd0;
        if (playSound) begin
            if (badColl)
                w_cls = 2'd3;
            else if (goodColl)
                w_cls = 2'd2;
            else if (|direction)
                w_cls = 2'd1;
        end
    end

    // Rising class only, so a held button or collision yields a single tone.
    assign w_trig = mode_i && (w_cls > r_cls_q);

    always_comb begin
        case (r_tone_cls)
            2'd2:    w_half = GOOD_HALF;
            2'd3:    w_half = BAD_HALF;
            default: w_half = MOVE_HALF;
        endcase
    end

    assign w_half_last = w_half - 1'b1;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= ST_IDLE;
            r_cls_q    <= 2'd0;
            r_tone_cls <= 2'd0;
            r_half_cnt <= '0;
            r_dur_cnt  <= '0;
            r_speaker  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cls_q <= w_cls;
            if (!mode_i) begin
                r_state    <= ST_IDLE;
                r_tone_cls <= 2'd0;
                r_half_cnt <= '0;
                r_dur_cnt  <= '0;
                r_speaker  <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_trig) begin
                            r_state    <= ST_PLAY;
                            r_tone_cls <= w_cls;
                            r_half_cnt <= '0;
                            r_dur_cnt  <= '0;
                            r_speaker  <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        // A higher-class event restarts the tone, even on its last cycle.
                        if (w_trig && (w_cls > r_tone_cls)) begin
                            r_tone_cls <= w_cls;
                            r_half_cnt <= '0;
                            r_dur_cnt  <= '0;
                            r_speaker  <= 1'b1;
                        end else if (r_dur_cnt == DUR_LAST) begin
                            r_state    <= ST_IDLE;
                            r_tone_cls <= 2'd0;
                            r_half_cnt <= '0;
                            r_dur_cnt  <= '0;
                            r_speaker  <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_dur_cnt <= r_dur_cnt + 1'b1;
                            if (r_half_cnt == w_half_last) begin
                                r_half_cnt <= '0;
                                r_speaker  <= ~r_speaker;
                            end else begin
                                r_half_cnt <= r_half_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign speaker  = r_speaker;
    assign busy     = r_busy;
    assign tone_cls = r_tone_cls;

endmodule

// File: tb/tb_sound_tone_gen.sv
// Directed bench for sound_tone_gen: a cycle-level tone model checked every cycle,
// plus hand-computed waveform, duration and priority expectations.
module tb_sound_tone_gen;

    localparam int MOVE_H = 2;
    localparam int GOOD_H = 3;
    localparam int BAD_H  = 5;
    localparam int DUR    = 20;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       playSound = 1'b0;
    logic       mode_i = 1'b1;
    logic       goodColl = 1'b0;
    logic       badColl = 1'b0;
    logic [3:0] direction = 4'd0;
    logic       speaker;
    logic       busy;
    logic [1:0] tone_cls;

    int checks = 0;
    int errors = 0;

    sound_tone_gen #(
        .PER_W(16), .DUR_W(24),
        .MOVE_HALF(16'd2), .GOOD_HALF(16'd3), .BAD_HALF(16'd5),
        .DUR_CYCLES(24'd20)
    ) dut (
        .clk(clk), .nRst(nRst), .playSound(playSound), .mode_i(mode_i),
        .goodColl(goodColl), .badColl(badColl), .direction(direction),
        .speaker(speaker), .busy(busy), .tone_cls(tone_cls)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a tone is "active" with a class and an elapsed-cycle count;
    // speaker is high during even half-periods of the elapsed time.
    bit m_active;
    int m_cls;
    int m_clsq;
    int m_elapsed;

    function automatic int half_of(input int c);
        return (c == 3) ? BAD_H : (c == 2) ? GOOD_H : MOVE_H;
    endfunction

    always @(posedge clk or negedge nRst) begin
        int c;
        bit t;
        if (!nRst) begin
            m_active  <= 1'b0;
            m_cls     <= 0;
            m_clsq    <= 0;
            m_elapsed <= 0;
        end else begin
            c = !playSound ? 0 : badColl ? 3 : goodColl ? 2 : (direction != 0) ? 1 : 0;
            t = mode_i && (c > m_clsq);
            m_clsq <= c;
            if (!mode_i) begin
                m_active <= 1'b0;
            end else if (m_active && t && c > m_cls) begin
                m_cls <= c;
                m_elapsed <= 0;
            end else if (!m_active && t) begin
                m_active <= 1'b1;
                m_cls <= c;
                m_elapsed <= 0;
            end else if (m_active) begin
                if (m_elapsed + 1 == DUR) m_active <= 1'b0;
                else m_elapsed <= m_elapsed + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (nRst) begin
            chk("model_busy", 32'(busy), 32'(m_active));
            chk("model_cls", 32'(tone_cls), m_active ? m_cls : 0);
            chk("model_spk", 32'(speaker),
                (m_active && ((m_elapsed / half_of(m_cls)) % 2 == 0)) ? 1 : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        playSound = 1'b0; goodColl = 1'b0; badColl = 1'b0; direction = 4'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit spk[0:63];
        int bcnt;
        int cls0;
        int n;

        step(2);
        nRst = 1'b1;
        step(1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_spk", 32'(speaker), 0);
        chk("reset_cls", 32'(tone_cls), 0);

        // Move held 50 cycles: one tone of 20 cycles, speaker 1,1,0,0.
        playSound = 1'b1; direction = 4'b0001;
        bcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            spk[i] = speaker;
            if (i == 0) cls0 = tone_cls;
            bcnt += busy;
        end
        chk("move_cls", cls0, 1);
        chk("move_busy_len", bcnt, 20);
        chk("move_spk_pat", {28'd0, spk[0], spk[1], spk[2], spk[3]}, 32'b1100);
        idle_inputs();
        step(3);

        // Move tone restarted by good collision; later move edge ignored.
        playSound = 1'b1; direction = 4'b0010;
        step(7);
        goodColl = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            spk[i] = speaker;
            if (i == 0) cls0 = tone_cls;
            if (i == 8) chk("restart_cls_hold", 32'(tone_cls), 2);
            bcnt += busy;
            if (i == 1) goodColl = 1'b0;
            if (i == 4) direction = 4'd0;
            if (i == 5) direction = 4'b0100;
        end
        chk("restart_cls", cls0, 2);
        chk("restart_busy_len", bcnt, 20);
        chk("restart_spk_pat", {26'd0, spk[0], spk[1], spk[2], spk[3], spk[4], spk[5]}, 32'b111000);
        idle_inputs();
        step(3);

        // Good and bad together: bad tone, half-period 5.
        playSound = 1'b1; goodColl = 1'b1; badColl = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            spk[i] = speaker;
            if (i == 0) cls0 = tone_cls;
            bcnt += busy;
        end
        chk("simul_cls", cls0, 3);
        chk("simul_busy_len", bcnt, 20);
        chk("simul_spk_pat", {21'd0, spk[0], spk[1], spk[2], spk[3], spk[4], spk[5],
                              spk[6], spk[7], spk[8], spk[9], spk[10]}, 32'b11111000001);
        idle_inputs();
        step(3);

        // Mode off aborts; events with mode off give no tone.
        playSound = 1'b1; direction = 4'b1000;
        step(5);
        chk("modeoff_pre_busy", 32'(busy), 1);
        mode_i = 1'b0;
        step(1);
        chk("modeoff_busy", 32'(busy), 0);
        chk("modeoff_spk", 32'(speaker), 0);
        chk("modeoff_cls", 32'(tone_cls), 0);
        goodColl = 1'b1;
        step(5);
        chk("modeoff_event_busy", 32'(busy), 0);
        mode_i = 1'b1;
        step(3);
        chk("modeon_held_busy", 32'(busy), 0);
        idle_inputs();
        step(3);

        // Back-to-back: new move edge right after busy falls.
        playSound = 1'b1; direction = 4'b0001;
        step(3);
        direction = 4'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        chk("b2b_busy_fall", 32'(busy), 0);
        chk("b2b_spk_low", 32'(speaker), 0);
        direction = 4'b0001;
        step(1);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_spk", 32'(speaker), 1);
        chk("b2b_cls", 32'(tone_cls), 1);

        // Asynchronous reset mid-tone.
        step(3);
        #2;
        nRst = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_spk", 32'(speaker), 0);
        chk("async_rst_cls", 32'(tone_cls), 0);
        idle_inputs();
        @(negedge clk);
        nRst = 1'b1;
        step(4);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_spk", 32'(speaker), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
